// File: rtl/toy_tage_ctr_table_if.sv
// toy_tage_ctr_table_if: lookup/update/flush bundle for the TAGE counter table
interface toy_tage_ctr_table_if #(
  parameter int IDX_W     = 10,
  parameter int CTR_WIDTH = 2
);
  logic                 flush;
  logic                 init_done;
  logic                 rd_en;
  logic [IDX_W-1:0]     rd_idx;
  logic                 rd_vld;
  logic [CTR_WIDTH-1:0] rd_data;
  logic                 upd_en;
  logic [IDX_W-1:0]     upd_idx;
  logic                 upd_taken;
  logic                 upd_rdy;
  modport master (
    output flush, rd_en, rd_idx, upd_en, upd_idx, upd_taken,
    input  init_done, rd_vld, rd_data, upd_rdy
  );
  modport slave (
    input  flush, rd_en, rd_idx, upd_en, upd_idx, upd_taken,
    output init_done, rd_vld, rd_data, upd_rdy
  );
endinterface

// File: rtl/toy_tage_ctr_table.sv
// toy_tage_ctr_table: saturating TAGE counter table with init sweep,
// registered lookup and a two-stage read-modify-write update pipeline.
module toy_tage_ctr_table #(
  parameter int ENTRY_NUM = 1024,
  parameter int CTR_WIDTH = 2,
  parameter int INIT_VAL  = 2
) (
  input logic clk,
  input logic rst,
  toy_tage_ctr_table_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]           state;
  logic [IDX_W-1:0]     ptr;
  logic                 u1_vld;
  logic [IDX_W-1:0]     u1_idx;
  logic                 u1_taken;
  logic [CTR_WIDTH-1:0] mem [ENTRY_NUM];
  logic [CTR_WIDTH-1:0] old_val;
  logic [CTR_WIDTH-1:0] dec;
  logic [CTR_WIDTH-1:0] new_val;
  logic [CTR_WIDTH:0]   inc;
  logic                 done;
  logic                 rd_acc;
  logic                 u1_wr;
  assign done          = state == S_RUN;
  assign bus.init_done = done;
  assign bus.upd_rdy   = done;
  assign rd_acc        = bus.rd_en & done & ~bus.flush;
  assign u1_wr         = u1_vld & ~bus.flush;
  // Array read is combinational, so a back-to-back update sees the previous write directly.
  always_comb begin
    old_val = mem[u1_idx];
    inc     = {1'b0, old_val} + (CTR_WIDTH+1)'(1);
    dec     = old_val - CTR_WIDTH'(1);
    new_val = u1_taken ? (inc[CTR_WIDTH] ? old_val : inc[CTR_WIDTH-1:0])
                       : (old_val == '0 ? old_val : dec);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      ptr         <= '0;
      u1_vld      <= 1'b0;
      u1_idx      <= '0;
      u1_taken    <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      if (bus.flush) begin
        state <= S_INIT;
        ptr   <= '0;
      end else if (state == S_INIT) begin
        ptr   <= ptr + IDX_W'(1);
        state <= ptr == IDX_W'(ENTRY_NUM - 1) ? S_RUN : S_INIT;
      end
      u1_vld <= bus.upd_en & done & ~bus.flush;
      if (bus.upd_en & done & ~bus.flush) begin
        u1_idx   <= bus.upd_idx;
        u1_taken <= bus.upd_taken;
      end
      bus.rd_vld <= rd_acc;
      if (rd_acc)
        bus.rd_data <= (u1_wr && bus.rd_idx == u1_idx) ? new_val : mem[bus.rd_idx];
    end
  end
  // No reset on the array; the sweep establishes every entry before use.
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      mem[ptr] <= CTR_WIDTH'(INIT_VAL);
    else if (u1_wr)
      mem[u1_idx] <= new_val;
  end
endmodule
